// File: rtl/decoder_pulse_seq_if.sv
// ============================================================================
// Module  : decoder_pulse_seq_if
// Brief   : Code-stream handshake bundle for decoder_pulse_seq.
//           in_par is present only when DECODER_PARITY_CHK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface decoder_pulse_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
`ifdef DECODER_PARITY_CHK_EN
    logic       in_par;

    modport master (output in_valid, output in_code, output in_par, input in_ready);
    modport slave  (input in_valid, input in_code, input in_par, output in_ready);
`else
    modport master (output in_valid, output in_code, input in_ready);
    modport slave  (input in_valid, input in_code, output in_ready);
`endif
endinterface

`default_nettype wire

// File: rtl/decoder_pulse_seq.sv
// ============================================================================
// Module  : decoder_pulse_seq
// Brief   : FIFO-buffered 3-to-8 decoder replaying each code as a one-hot
//           pulse of PULSE_W cycles separated by GAP_W idle cycles.
//           Optional parity check: define DECODER_PARITY_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_pulse_seq #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 1,
    parameter int DEPTH   = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    decoder_pulse_seq_if.slave    in_if,
    output logic [7:0]            out,
    output logic                  out_valid,
    output logic                  busy
`ifdef DECODER_PARITY_CHK_EN
    ,
    output logic                  par_err
`endif
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [7:0]  C_PULSE_LOAD = 8'(PULSE_W - 1);
    localparam logic [7:0]  C_GAP_LOAD   = (GAP_W > 0) ? 8'(GAP_W - 1) : 8'd0;
    localparam logic [AW:0] C_PTR_ONE    = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]  mem_q [DEPTH];
    logic [2:0]  mem_d [DEPTH];

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_load;
    logic [2:0]  w_head;

    // Extra MSB on each pointer tells a full FIFO from an empty one.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_head  = mem_q[rd_ptr_q[AW-1:0]];

    assign in_if.in_ready = !w_full;
    assign out            = out_q;
    assign out_valid      = out_valid_q;
    assign busy           = (state_q != IDLE) || !w_empty;

`ifdef DECODER_PARITY_CHK_EN
    logic w_par_ok;
    logic par_err_q, par_err_d;

    // A bad-parity word still completes the handshake but is dropped.
    assign w_par_ok = ~^{in_if.in_par, in_if.in_code};
    assign w_push   = in_if.in_valid && !w_full && w_par_ok;
    assign par_err  = par_err_q;

    always_comb begin
        par_err_d = par_err_q | (in_if.in_valid && !w_full && !w_par_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`else
    assign w_push = in_if.in_valid && !w_full;
`endif

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_if.in_code;
            wr_ptr_d                = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        w_pop       = 1'b0;
        w_load      = 1'b0;

        case (state_q)
            IDLE: begin
                out_d       = 8'h00;
                out_valid_d = 1'b0;
                w_load      = !w_empty;
            end
            DRIVE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (GAP_W > 0) begin
                    out_d       = 8'h00;
                    out_valid_d = 1'b0;
                    cnt_d       = C_GAP_LOAD;
                    state_d     = GAP;
                end else if (!w_empty) begin
                    w_load = 1'b1;
                end else begin
                    out_d       = 8'h00;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (!w_empty) begin
                    w_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                out_d       = 8'h00;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Every path that starts a pulse shares this pop-and-load step.
        if (w_load) begin
            w_pop       = 1'b1;
            out_d       = 8'b1 << w_head;
            out_valid_d = 1'b1;
            cnt_d       = C_PULSE_LOAD;
            state_d     = DRIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decoder_pulse_seq.sv
// ============================================================================
// Module  : tb_decoder_pulse_seq
// Brief   : Bench for decoder_pulse_seq; drives a GAP_W=1 and a GAP_W=0
//           instance from one stimulus stream against a pulse-schedule model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_pulse_seq;

    localparam int PW    = 4;
    localparam int DEPTH = 4;
    localparam int MAXP  = 1024;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tb_valid = 1'b0;
    logic [2:0] tb_code  = 3'd0;
    logic       tb_par   = 1'b0;

    logic [7:0] out_a, out_b;
    logic       ov_a, ov_b, busy_a, busy_b;
    logic       perr_a, perr_b;

    decoder_pulse_seq_if if_a ();
    decoder_pulse_seq_if if_b ();

    assign if_a.in_valid = tb_valid;
    assign if_a.in_code  = tb_code;
    assign if_b.in_valid = tb_valid;
    assign if_b.in_code  = tb_code;

`ifdef DECODER_PARITY_CHK_EN
    assign if_a.in_par = tb_par;
    assign if_b.in_par = tb_par;
`else
    assign perr_a = 1'b0;
    assign perr_b = 1'b0;
`endif

    decoder_pulse_seq #(.PULSE_W(PW), .GAP_W(1), .DEPTH(DEPTH)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_if     (if_a.slave),
        .out       (out_a),
        .out_valid (ov_a),
        .busy      (busy_a)
`ifdef DECODER_PARITY_CHK_EN
        ,
        .par_err   (perr_a)
`endif
    );

    decoder_pulse_seq #(.PULSE_W(PW), .GAP_W(0), .DEPTH(DEPTH)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_if     (if_b.slave),
        .out       (out_b),
        .out_valid (ov_b),
        .busy      (busy_b)
`ifdef DECODER_PARITY_CHK_EN
        ,
        .par_err   (perr_b)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Schedule model: code i is pushed at edge pp, starts at edge ps and
    // occupies [ps, ps+PW); the FSM is non-idle over [ps, ps+PW+gap).
    int   pp [2][MAXP];
    int   ps [2][MAXP];
    int   pc [2][MAXP];
    int   np [2];
    int   last_s [2];
    logic perr_m [2];
    int   t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic int held(input int d, input int tt);
        int n = 0;
        for (int i = 0; i < np[d]; i++)
            if (pp[d][i] <= tt && ps[d][i] > tt) n++;
        return n;
    endfunction

    function automatic logic [7:0] exp_out(input int d, input int tt);
        logic [7:0] one = 8'h01;
        for (int i = 0; i < np[d]; i++)
            if (ps[d][i] <= tt && tt < ps[d][i] + PW) return one << pc[d][i];
        return 8'h00;
    endfunction

    function automatic logic exp_busy(input int d, input int tt);
        if (held(d, tt) > 0) return 1'b1;
        for (int i = 0; i < np[d]; i++)
            if (ps[d][i] <= tt && tt < ps[d][i] + PW + gap_of(d)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            np[d]     = 0;
            last_s[d] = -1000;
            perr_m[d] = 1'b0;
        end
        t = 0;
    endtask

    // One clock of stimulus; predicts acceptance, then checks outputs after the edge.
    task automatic step(input logic v, input logic [2:0] c, input logic bad);
        logic good;
        logic rdy;
        logic [7:0] o;
        tb_valid = v;
        tb_code  = c;
        tb_par   = (^c) ^ bad;
`ifdef DECODER_PARITY_CHK_EN
        good = ~^{tb_par, c};
`else
        good = 1'b1;
`endif
        for (int d = 0; d < 2; d++) begin
            rdy = (held(d, t - 1) < DEPTH);
            chk(d == 0 ? "in_ready_a" : "in_ready_b",
                d == 0 ? if_a.in_ready : if_b.in_ready, rdy);
            if (v && rdy) begin
                if (!good) begin
                    perr_m[d] = 1'b1;
                end else if (np[d] < MAXP) begin
                    pp[d][np[d]] = t;
                    ps[d][np[d]] = (t + 1 > last_s[d] + PW + gap_of(d)) ?
                                   t + 1 : last_s[d] + PW + gap_of(d);
                    pc[d][np[d]] = c;
                    last_s[d]    = ps[d][np[d]];
                    np[d]++;
                end
            end
        end
        @(posedge clk);
        #1;
        o = exp_out(0, t);
        chk("out_a", out_a, o);
        chk("out_valid_a", ov_a, o != 8'h00);
        chk("busy_a", busy_a, exp_busy(0, t));
        o = exp_out(1, t);
        chk("out_b", out_b, o);
        chk("out_valid_b", ov_b, o != 8'h00);
        chk("busy_b", busy_b, exp_busy(1, t));
`ifdef DECODER_PARITY_CHK_EN
        chk("par_err_a", perr_a, perr_m[0]);
        chk("par_err_b", perr_b, perr_m[1]);
`endif
        t++;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tb_valid = 1'b1;
        tb_code  = 3'd6;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_a", out_a, 8'h00);
        chk("rst_ov_a", ov_a, 1'b0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_out_b", out_b, 8'h00);
        chk("rst_busy_b", busy_b, 1'b0);
        chk("rst_perr_a", perr_a, 1'b0);
        rst_n    = 1'b1;
        tb_valid = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       v;
        logic [2:0] c;
        logic [7:0] eo;
        logic       eb;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] tr  [$];
    logic [7:0] exp_g0 [10];
    logic [7:0] one8 = 8'h01;

    initial begin
        int i, low, first, dens;
        logic acc;

        tbl[0] = '{1'b1, 3'd3, 8'h00, 1'b1};
        tbl[1] = '{1'b0, 3'd0, 8'h08, 1'b1};
        tbl[2] = '{1'b0, 3'd0, 8'h08, 1'b1};
        tbl[3] = '{1'b0, 3'd0, 8'h08, 1'b1};
        tbl[4] = '{1'b0, 3'd0, 8'h08, 1'b1};
        tbl[5] = '{1'b0, 3'd0, 8'h00, 1'b1};
        tbl[6] = '{1'b0, 3'd0, 8'h00, 1'b0};
        tbl[7] = '{1'b0, 3'd0, 8'h00, 1'b0};
        exp_g0 = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80,
                   8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        model_reset();

        // Reset with in_valid high: nothing may be queued.
        do_reset();
        repeat (4) step(1'b0, 3'd0, 1'b0);

        // Single code 3, table-driven on the GAP_W=1 instance.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tb_valid = tbl[k].v;
            tb_code  = tbl[k].c;
            tb_par   = ^tbl[k].c;
            @(posedge clk);
            #1;
            chk("tbl_out", out_a, tbl[k].eo);
            chk("tbl_valid", ov_a, tbl[k].eo != 8'h00);
            chk("tbl_busy", busy_a, tbl[k].eb);
            t = k;
        end

        // Burst of 0..5 with valid held until each is accepted.
        do_reset();
        i   = 0;
        low = 0;
        tr.delete();
        for (int k = 0; k < 60 && i < 6; k++) begin
            acc = if_a.in_ready;
            if (!acc) low++;
            step(1'b1, 3'(i), 1'b0);
            tr.push_back(out_a);
            if (acc) i++;
        end
        chk("burst_accepted", i, 6);
        chk("burst_ready_dropped", low > 0, 1'b1);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 3'd0, 1'b0);
            tr.push_back(out_a);
        end
        first = -1;
        for (int k = 0; k < tr.size(); k++)
            if (first < 0 && tr[k] != 8'h00) first = k;
        chk("burst_start_found", first >= 0, 1'b1);
        if (first >= 0 && first + 30 <= tr.size()) begin
            for (int j = 0; j < 6; j++)
                for (int k = 0; k < 5; k++)
                    chk("burst_seq", tr[first + j*5 + k],
                        (k < 4) ? (one8 << j) : 8'h00);
        end

        // GAP_W=0 instance: 7 then 0 back to back, no zero cycle between.
        do_reset();
        tr.delete();
        step(1'b1, 3'd7, 1'b0);
        tr.push_back(out_b);
        step(1'b1, 3'd0, 1'b0);
        tr.push_back(out_b);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 3'd0, 1'b0);
            tr.push_back(out_b);
        end
        for (int k = 0; k < 10; k++)
            chk("gap0_seq", tr[k], exp_g0[k]);

        // Randomized traffic with varying offered load.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            case ((k / 250) % 5)
                0: dens = 90;
                1: dens = 20;
                2: dens = 60;
                3: dens = 100;
                default: dens = 40;
            endcase
            step($urandom_range(0, 99) < dens, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 63) == 0);
        end

        // Asynchronous reset mid-DRIVE with codes still queued.
        do_reset();
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        step(1'b1, 3'd4, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        chk("pre_areset_out", out_a, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_a", out_a, 8'h00);
        chk("areset_ov_a", ov_a, 1'b0);
        chk("areset_out_b", out_b, 8'h00);
        chk("areset_busy_a", busy_a, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (20) step(1'b0, 3'd0, 1'b0);

`ifdef DECODER_PARITY_CHK_EN
        // Bad-parity 5 is dropped, good-parity 2 is emitted.
        do_reset();
        step(1'b1, 3'd5, 1'b1);
        chk("par_err_set", perr_a, 1'b1);
        step(1'b1, 3'd2, 1'b0);
        repeat (14) step(1'b0, 3'd0, 1'b0);
        chk("par_err_sticky", perr_a, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0d actual=timeout required=finish", t);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/decoder_pulse_seq.md
Name: decoder_pulse_seq

Overview:
Sequential 3-to-8 decoder, the receive-side counterpart of the team's 8-to-3 encoder. It accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO. Each code is replayed as a one-hot 8-bit pulse of programmable width, with a programmable idle gap between pulses. It drives one-hot select/strobe lines from a compact code stream.

Parameters:
PULSE_W, 4, cycles each one-hot word is held on out; legal range 1..255
GAP_W, 1, all-zero cycles inserted between consecutive pulses; legal range 0..255
DEPTH, 4, input FIFO entries; power of two, at least 2

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_code is valid
in_ready  output  1  FIFO can accept; combinational, equals !full
in_code  input  3  binary code, 0..7
out  output  8  registered one-hot word; all zeros when not driving
out_valid  output  1  registered; high exactly while out is non-zero
busy  output  1  combinational; high when state != IDLE or FIFO not empty

Behaviour:
- Reset (async assert, sync release):
  - out = 8'h00, out_valid = 0, state = IDLE, FIFO empty.
  - Counters = 0.
  - in_ready = 1 once reset releases.
- Reset mid-operation: out drops to 0 immediately and all queued codes are discarded.
- Push: a push happens on a rising edge where in_valid && in_ready. in_code is written at the FIFO tail.
- Full FIFO: in_ready = 0, even on a cycle where the FSM pops. No simultaneous push-on-full.
- Wrap-around: read and write pointers are log2(DEPTH) bits, plus one extra bit that distinguishes full from empty.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE:
    - If FIFO not empty: pop head; out <= 8'b1 << code; out_valid <= 1; cnt <= PULSE_W-1; go to DRIVE.
    - Otherwise stay; out = 0.
  - DRIVE: hold out. If cnt != 0, cnt <= cnt-1. When cnt == 0:
    - GAP_W > 0: out <= 0; out_valid <= 0; cnt <= GAP_W-1; go to GAP.
    - GAP_W == 0 and FIFO not empty: pop next and load it directly. No zero cycle between pulses.
    - GAP_W == 0 and FIFO empty: out <= 0; go to IDLE.
  - GAP: out = 0. If cnt != 0, decrement. When cnt == 0:
    - FIFO not empty: pop and load directly into DRIVE.
    - FIFO empty: go to IDLE.
- Latency: a code pushed at edge k into an empty FIFO while IDLE appears on out from edge k+1. It is held for exactly PULSE_W cycles.
- Pulse period: back-to-back queued codes produce a period of PULSE_W + GAP_W cycles.
- Ordering: codes replay strictly in push order.
- Input width: in_code is exactly 3 bits, so no invalid code exists and no default/X output is produced.
- Counter width: the cnt register is 8 bits.

Optional Feature:
Macro DECODER_PARITY_CHK_EN.
- Defined:
  - Adds input in_par (1 bit) and output par_err (1 bit, registered, reset 0).
  - Good parity: ^{in_par, in_code} == 0 (even parity).
  - Bad parity: the handshake still completes, since in_ready is unaffected. The code is not written to the FIFO. par_err sets and stays high until reset.
- Not defined: in_par and par_err do not exist, and every accepted code is queued.

Test Plan:
(All with PULSE_W=4, GAP_W=1, DEPTH=4 unless noted.)
- Reset: hold rst_n=0 with in_valid=1 -> out=8'h00, out_valid=0, busy=0. After release, in_ready=1 and nothing is queued during reset.
- Single code: in_code=3 pushed at edge k -> out=8'h08, out_valid=1 for edges k+1..k+4. out=0 at k+5. busy=0 from k+6.
- Burst of 6 codes (0..5) with in_valid held high -> in_ready drops to 0 once 4 entries are held. Output sequence is 01,02,04,08,10,20, each held 4 cycles, each separated by exactly one 00 cycle.
- Instance with GAP_W=0, codes 7 then 0 queued -> out=80 for 4 cycles, then 01 for 4 cycles with no 00 cycle between.
- Async reset: assert rst_n=0 mid-DRIVE with 3 codes queued -> out=0 without waiting for a clock edge. After release, busy=0 and no stale pulses appear.
- With DECODER_PARITY_CHK_EN: push code 5 with in_par=1 (bad parity), then code 2 with in_par=1 (good parity) -> only 8'h04 is emitted, and par_err=1 sticky from the edge after the first push.
